// File: rtl/aes_key_stream_if.sv
// Job types plus the start/round-key bus of aes_key_stream.
//
// sysdef_pkg::job_t : ENCRYPT, DECRYPT, and two reserved codes.
//   The reserved codes are accepted and handled as ENCRYPT.
//
// aes_key_stream_if signals:
//   start_valid/start_ready : start request (key_in, in_type)
//   rk_valid/rk_ready       : round-key stream (rk_out, rk_idx, rk_last)
//   busy                    : the sequencer is not idle
//
// Handshake rule, used by both channels:
//   - A transfer happens on a rising clock edge where valid and ready are both 1.
//   - Once the sender raises valid, it holds valid and its payload stable
//     until that transfer happens.
//   - Ready may change freely from cycle to cycle.
//   - On the start channel, the requester may keep start_valid high.
//     This lets it queue its next job.
//
// Modports:
//   slave  : the key sequencer
//   master : the job issuer, which also consumes the round keys
package sysdef_pkg;
  typedef enum logic [1:0] {
    ENCRYPT   = 2'd0,
    DECRYPT   = 2'd1,
    JOB_RSVD2 = 2'd2,
    JOB_RSVD3 = 2'd3
  } job_t;
endpackage

interface aes_key_stream_if;
  import sysdef_pkg::*;

  logic         start_valid;
  logic         start_ready;
  logic [127:0] key_in;
  job_t         in_type;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  modport slave (
    input  start_valid, key_in, in_type, rk_ready,
    output start_ready, rk_valid, rk_out, rk_idx, rk_last, busy
  );

  modport master (
    output start_valid, key_in, in_type, rk_ready,
    input  start_ready, rk_valid, rk_out, rk_idx, rk_last, busy
  );
endinterface

// File: rtl/aes_key_stream.sv
// AES-128 round-key sequencer.
//
// Takes a cipher key and a job type.
// Streams the 11 round keys over a valid/ready channel:
//   - rounds 0..10 for ENCRYPT
//   - rounds 10..0 for DECRYPT
//
// Decrypt first expands forward to round 10, one round per cycle.
// It then walks backwards with the inverse recurrence.
// Only the current round key is ever stored.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   ks          : start + round-key bus (slave side)
//   state_dbg_o : current FSM state (0 IDLE, 1 EXPAND, 2 STREAM)
module aes_key_stream (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_stream_if.slave    ks,
  output logic [1:0]         state_dbg_o
);
  import sysdef_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  // Forward AES S-box. Byte 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // The top byte holds entry 0, so ~b * 8 is the LSB offset of entry b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q;
  logic [127:0] rk_q;
  logic [3:0]   idx_q;
  logic         dec_q;

  logic [127:0] rk_d;
  logic [3:0]   idx_d;
  logic         inv_step;
  logic         last;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, t;
  logic [31:0]  f0, f1, f2, f3;
  logic [3:0]   rc_idx;

  // One shared SubWord(RotWord()) feeds both directions.
  // The forward step uses w3.
  // The inverse step first recovers the previous w3 as w3' ^ w2'.
  // That recovered word then goes through the same S-box lookups.
  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    inv_step = (state_q == S_STREAM) && dec_q;
    sub_in   = inv_step ? (w3 ^ w2) : w3;
    rc_idx   = inv_step ? idx_q : idx_q + 4'd1;
    t        = {sbox(sub_in[23:16]), sbox(sub_in[15:8]),
                sbox(sub_in[7:0]),   sbox(sub_in[31:24])} ^ {rcon(rc_idx), 24'h0};
    f0 = w0 ^ t;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    rk_d  = inv_step ? {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2} : {f0, f1, f2, f3};
    idx_d = inv_step ? idx_q - 4'd1 : idx_q + 4'd1;
    last  = dec_q ? (idx_q == 4'd0) : (idx_q == 4'd10);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ks.start_valid) begin
            rk_q    <= ks.key_in;
            idx_q   <= 4'd0;
            dec_q   <= (ks.in_type == DECRYPT);
            state_q <= (ks.in_type == DECRYPT) ? S_EXPAND : S_STREAM;
          end
        end
        S_EXPAND: begin
          rk_q  <= rk_d;
          idx_q <= idx_d;
          if (idx_d == 4'd10) state_q <= S_STREAM;
        end
        S_STREAM: begin
          if (ks.rk_ready) begin
            if (last) begin
              state_q <= S_IDLE;
            end else begin
              rk_q  <= rk_d;
              idx_q <= idx_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All outputs come from registers only.
  // Outside STREAM they are forced to zero, so a stale key is never visible.
  assign ks.rk_valid    = (state_q == S_STREAM);
  assign ks.rk_out      = (state_q == S_STREAM) ? rk_q : '0;
  assign ks.rk_idx      = (state_q == S_STREAM) ? idx_q : '0;
  assign ks.rk_last     = (state_q == S_STREAM) && last;
  assign ks.busy        = (state_q != S_IDLE);
  assign ks.start_ready = (state_q == S_IDLE);
  assign state_dbg_o    = state_q;
endmodule

// File: tb/tb_aes_key_stream.sv
module tb_aes_key_stream;
  import sysdef_pkg::*;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_stream_if ks_if();
  logic [1:0] state_dbg;

  aes_key_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ks          (ks_if),
    .state_dbg_o (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [127:0] exp_q[$];
  logic [127:0] model_rk[11];
  logic [127:0] cap[11];
  logic [127:0] enc_cap[11];
  logic [7:0]   sbox_tb[256];
  logic [2047:0] sbox_flat;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference model: the textbook FIPS-197 word-array key expansion.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]], sbox_tb[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_expect(input bit dec);
    exp_q.delete();
    for (int r = 0; r < 11; r++) exp_q.push_back(model_rk[dec ? 10 - r : r]);
  endtask

  // driver: entered and left at a falling edge
  task automatic start_job(input logic [127:0] key, input job_t jt);
    int g = 0;
    while (ks_if.start_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (ks_if.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_wait: got %b want 1", ks_if.start_ready);
    end
    ks_if.start_valid = 1'b1;
    ks_if.key_in      = key;
    ks_if.in_type     = jt;
    @(posedge clk);
    @(negedge clk);
    ks_if.start_valid = 1'b0;
  endtask

  // Consumes one stream.
  // Called at the falling edge in the cycle after the start edge.
  task automatic collect(input bit dec, input bit rnd_ready, input bit noise, input int exp_lat);
    int lat;
    int got;
    int guard;
    bit r;
    bit held;
    logic [127:0] h_out;
    logic [3:0]   h_idx;
    logic         h_last;
    logic [3:0]   e_idx;
    lat = 1;
    ks_if.rk_ready = 1'b0;
    while (ks_if.rk_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (ks_if.rk_valid !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d cycles (valid=%b) want %0d", lat, ks_if.rk_valid, exp_lat);
    end
    got = 0;
    held = 1'b0;
    guard = 0;
    h_out = '0;
    h_idx = '0;
    h_last = 1'b0;
    while (got < 11 && guard < 400) begin
      guard++;
      checks++;
      if (ks_if.rk_valid !== 1'b1) begin
        errors++;
        $display("FAIL valid_gap: got rk_valid=%b want 1 after %0d keys", ks_if.rk_valid, got);
        break;
      end
      if (held) begin
        checks++;
        if ({ks_if.rk_out, ks_if.rk_idx, ks_if.rk_last} !== {h_out, h_idx, h_last}) begin
          errors++;
          $display("FAIL stall_stable: got %h/%0d/%b want %h/%0d/%b", ks_if.rk_out, ks_if.rk_idx,
                   ks_if.rk_last, h_out, h_idx, h_last);
        end
      end
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ks_if.rk_ready = r;
      if (noise) begin
        ks_if.start_valid = 1'($urandom_range(0, 1));
        ks_if.key_in      = {$urandom, $urandom, $urandom, $urandom};
        ks_if.in_type     = job_t'(2'($urandom_range(0, 3)));
      end
      if (r) begin
        e_idx = dec ? 4'(10 - got) : 4'(got);
        checks++;
        if (ks_if.rk_out !== exp_q[0]) begin
          errors++;
          $display("FAIL rk_out[%0d]: got %h want %h", e_idx, ks_if.rk_out, exp_q[0]);
        end
        checks++;
        if (ks_if.rk_idx !== e_idx) begin
          errors++;
          $display("FAIL rk_idx: got %0d want %0d", ks_if.rk_idx, e_idx);
        end
        checks++;
        if (ks_if.rk_last !== (got == 10)) begin
          errors++;
          $display("FAIL rk_last[%0d]: got %b want %b", e_idx, ks_if.rk_last, (got == 10));
        end
        cap[e_idx] = ks_if.rk_out;
        void'(exp_q.pop_front());
        got++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        h_out  = ks_if.rk_out;
        h_idx  = ks_if.rk_idx;
        h_last = ks_if.rk_last;
      end
      @(negedge clk);
    end
    ks_if.rk_ready = 1'b0;
    if (noise) ks_if.start_valid = 1'b0;
    checks++;
    if (got != 11) begin
      errors++;
      $display("FAIL stream_count: got %0d keys want 11", got);
    end
    checks++;
    if (ks_if.rk_valid !== 1'b0 || ks_if.start_ready !== 1'b1) begin
      errors++;
      $display("FAIL end_of_stream: got valid=%b start_ready=%b want 0/1", ks_if.rk_valid, ks_if.start_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ks_if.rk_valid, ks_if.rk_out, ks_if.rk_idx, ks_if.rk_last, ks_if.busy, ks_if.start_ready}
        !== {1'b0, 128'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b out=%h idx=%0d last=%b busy=%b sr=%b want 0/0/0/0/0/1",
               ks_if.rk_valid, ks_if.rk_out, ks_if.rk_idx, ks_if.rk_last, ks_if.busy, ks_if.start_ready);
    end
  endtask

  task automatic test_kat(input logic [127:0] key, input logic [127:0] want1, input logic [127:0] want10);
    build_model(key);
    for (int d = 0; d < 2; d++) begin
      load_expect(d[0]);
      start_job(key, d[0] ? DECRYPT : ENCRYPT);
      collect(d[0], 1'b0, 1'b0, d[0] ? 11 : 1);
      checks++;
      if (cap[0] !== key || cap[1] !== want1 || cap[10] !== want10) begin
        errors++;
        $display("FAIL kat_dir%0d: got %h %h %h want %h %h %h", d, cap[0], cap[1], cap[10], key, want1, want10);
      end
      if (d == 0) enc_cap = cap;
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (cap[i] !== enc_cap[i]) begin
        errors++;
        $display("FAIL dec_vs_enc[%0d]: got %h want %h", i, cap[i], enc_cap[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    job_t jt;
    bit dec;
    for (int it = 0; it < 6; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      jt  = job_t'(2'($urandom_range(0, 3)));
      dec = (jt == DECRYPT);
      build_model(key);
      load_expect(dec);
      start_job(key, jt);
      collect(dec, 1'b1, 1'b1, dec ? 11 : 1);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] key;
    int g;
    int seen;
    for (int ph = 0; ph < 2; ph++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      if (ph == 0) begin
        start_job(key, DECRYPT);
        repeat (3) @(negedge clk);
      end else begin
        start_job(key, ENCRYPT);
        ks_if.rk_ready = 1'b1;
        g = 0;
        while (!(ks_if.rk_valid === 1'b1 && ks_if.rk_idx === 4'd5) && g < 40) begin
          @(negedge clk);
          g++;
        end
        checks++;
        if (ks_if.rk_idx !== 4'd5) begin
          errors++;
          $display("FAIL reach_idx5: got %0d want 5", ks_if.rk_idx);
        end
        ks_if.rk_ready = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({ks_if.rk_valid, ks_if.rk_out, ks_if.rk_idx, ks_if.rk_last, ks_if.busy, ks_if.start_ready}
          !== {1'b0, 128'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL mid_reset%0d: got v=%b out=%h idx=%0d last=%b busy=%b sr=%b want 0/0/0/0/0/1", ph,
                 ks_if.rk_valid, ks_if.rk_out, ks_if.rk_idx, ks_if.rk_last, ks_if.busy, ks_if.start_ready);
      end
      seen = 0;
      ks_if.rk_ready = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (ks_if.rk_valid === 1'b1) seen++;
      end
      ks_if.rk_ready = 1'b0;
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL post_reset_keys: got %0d valid cycles want 0", seen);
      end
    end
    key = {$urandom, $urandom, $urandom, $urandom};
    build_model(key);
    load_expect(1'b1);
    start_job(key, DECRYPT);
    collect(1'b1, 1'b0, 1'b0, 11);
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka;
    logic [127:0] kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    build_model(ka);
    load_expect(1'b0);
    ks_if.start_valid = 1'b1;
    ks_if.key_in      = ka;
    ks_if.in_type     = ENCRYPT;
    @(posedge clk);
    @(negedge clk);
    ks_if.key_in  = kb;
    ks_if.in_type = DECRYPT;
    collect(1'b0, 1'b0, 1'b0, 1);
    build_model(kb);
    load_expect(1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ks_if.busy !== 1'b1 || ks_if.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b valid=%b want 1/0", ks_if.busy, ks_if.rk_valid);
    end
    ks_if.start_valid = 1'b0;
    collect(1'b1, 1'b0, 1'b0, 11);
  endtask

  initial begin
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    for (int i = 0; i < 256; i++) sbox_tb[i] = sbox_flat[2047-8*i -: 8];
    rst_n             = 1'b0;
    ks_if.start_valid = 1'b0;
    ks_if.key_in      = '0;
    ks_if.in_type     = ENCRYPT;
    ks_if.rk_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_kat(K0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    test_kat(K1, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
